bcd_counter_n: RTL and testbench

Parametrised multi-digit modulo counter, the successor to the single-digit decade counter. It counts in DIGITS cascaded digits of radix RADIX (default: BCD decade), with enable, synchronous parallel load, optional down-counting, a terminal-count flag and a registered wrap pulse. It drives display digit registers and timebase dividers in the FPGA training designs, and cascades across instances through `en`/`tc`.

---
 rtl/bcd_counter_n_pkg.sv | 17 +
 rtl/bcd_counter_n_digit.sv | 84 ++++++++
 rtl/bcd_counter_n.sv | 107 ++++++++++
 tb/tb_bcd_counter_n.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_n_pkg.sv
// ---------------------------------------------------------------------------
// bcd_counter_n_pkg
// Shared constants and types for the multi-digit modulo counter.
//   DIGIT_W    : width of one digit register (always 4 bits)
//   MAX_DIGITS : largest supported DIGITS parameter
//   MAX_RADIX  : largest supported per-digit modulus
//   digit_t    : one digit value
// ---------------------------------------------------------------------------
package bcd_counter_n_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;
    localparam int MAX_RADIX  = 16;

    typedef logic [DIGIT_W-1:0] digit_t;

endpackage : bcd_counter_n_pkg

// File: rtl/bcd_counter_n_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One digit of the cascaded counter: a 4-bit register that counts modulo
// RADIX, with synchronous parallel load and an illegal-value clamp.
//
// Optional feature macro: COUNTER_DOWN_EN (compiles in decrement support).
//
// Ports:
//   clk        in  : rising-edge clock
//   rst        in  : synchronous active-low reset
//   load       in  : load load_digit (values >= RADIX are stored as 0)
//   load_digit in  : value to load
//   step       in  : advance this digit by one in the selected direction
//   up         in  : direction, 1 = up (ignored without COUNTER_DOWN_EN)
//   q          out : registered digit value
//   at_max     out : q == RADIX-1
//   at_min     out : q == 0 (tied low without COUNTER_DOWN_EN)
// ---------------------------------------------------------------------------
module bcd_digit
    import bcd_counter_n_pkg::*;
#(
    parameter int RADIX = 10
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  digit_t load_digit,
    input  logic   step,
    input  logic   up,
    output digit_t q,
    output logic   at_max,
    output logic   at_min
);

    localparam digit_t MAX_VAL = digit_t'(RADIX - 1);

    digit_t q_reg;
    digit_t q_next;
    digit_t inc_val;

    assign at_max  = (q_reg == MAX_VAL);
    assign inc_val = at_max ? digit_t'(0) : q_reg + digit_t'(1);

`ifdef COUNTER_DOWN_EN
    digit_t dec_val;

    assign at_min  = (q_reg == digit_t'(0));
    assign dec_val = at_min ? MAX_VAL : q_reg - digit_t'(1);

    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = (load_digit <= MAX_VAL) ? load_digit : digit_t'(0);
        end else if (step) begin
            q_next = up ? inc_val : dec_val;
        end
    end
`else
    logic unused_up;

    assign unused_up = up;
    assign at_min    = 1'b0;

    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = (load_digit <= MAX_VAL) ? load_digit : digit_t'(0);
        end else if (step) begin
            q_next = inc_val;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule : bcd_digit

// File: rtl/bcd_counter_n.sv
// ---------------------------------------------------------------------------
// bcd_counter_n
// DIGITS cascaded modulo-RADIX digits with enable, synchronous load,
// optional down counting, combinational terminal count and a registered
// wrap pulse. Instances cascade by driving the next instance's en from tc.
//
// Optional feature macro: COUNTER_DOWN_EN (up port selects direction;
// without it the counter counts up only and up is ignored).
//
// Ports:
//   clk      in  : rising-edge clock
//   rst      in  : synchronous active-low reset
//   en       in  : count enable
//   up       in  : direction, 1 = up, 0 = down
//   load     in  : synchronous parallel load (beats en)
//   load_val in  : load value, digit 0 in bits [3:0]
//   cnt      out : registered count, digit 0 in bits [3:0]
//   tc       out : en AND all digits at the terminal value for the direction
//   wrap     out : one-cycle pulse while cnt shows the wrapped value
// ---------------------------------------------------------------------------
module bcd_counter_n
    import bcd_counter_n_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int RADIX  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      up,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    output logic [DIGIT_W*DIGITS-1:0] cnt,
    output logic                      tc,
    output logic                      wrap
);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] step;
    logic              dir_up;
    logic              wrap_reg;

    // carry_up[k] is high when en is set and digits 0..k-1 are all at
    // RADIX-1; carry_up[DIGITS] is therefore the full-counter terminal.
    logic [DIGITS:0]   carry_up;

    assign carry_up[0] = en;

`ifdef COUNTER_DOWN_EN
    // Borrow chain mirrors the carry chain for the all-zero condition.
    logic [DIGITS:0]   carry_dn;

    assign carry_dn[0] = en;
    assign dir_up      = up;
    assign tc          = dir_up ? carry_up[DIGITS] : carry_dn[DIGITS];
`else
    logic unused_down;

    assign unused_down = &{1'b0, up, at_min};
    assign dir_up      = 1'b1;
    assign tc          = carry_up[DIGITS];
`endif

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            digit_t q_digit;

            assign carry_up[gi+1] = carry_up[gi] & at_max[gi];
`ifdef COUNTER_DOWN_EN
            assign carry_dn[gi+1] = carry_dn[gi] & at_min[gi];
            assign step[gi]       = dir_up ? carry_up[gi] : carry_dn[gi];
`else
            assign step[gi]       = carry_up[gi];
`endif

            bcd_digit #(
                .RADIX (RADIX)
            ) u_digit (
                .clk        (clk),
                .rst        (rst),
                .load       (load),
                .load_digit (load_val[gi*DIGIT_W +: DIGIT_W]),
                .step       (step[gi]),
                .up         (dir_up),
                .q          (q_digit),
                .at_max     (at_max[gi]),
                .at_min     (at_min[gi])
            );

            assign cnt[gi*DIGIT_W +: DIGIT_W] = q_digit;
        end
    endgenerate

    // The wrapped value appears on the edge that consumes tc, so registering
    // tc (minus load, which overrides the step) lines the pulse up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap_reg <= 1'b0;
        end else begin
            wrap_reg <= tc & ~load;
        end
    end

    assign wrap = wrap_reg;

endmodule : bcd_counter_n

// File: tb/tb_bcd_counter_n.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter_n
// Directed bench for bcd_counter_n with DIGITS=2, RADIX=10. Down-count
// scenarios are compiled when COUNTER_DOWN_EN is defined, otherwise the
// up-only behaviour with up=0 is checked.
// ---------------------------------------------------------------------------
module tb_bcd_counter_n;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] cnt;
    logic       tc;
    logic       wrap;

    int errors = 0;
    int checks = 0;
    int model;

    bcd_counter_n #(
        .DIGITS (2),
        .RADIX  (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .tc       (tc),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'h00;

        // Reset held two cycles with en high.
        tick();
        tick();
        $display("reset: cnt=%h wrap=%b", cnt, wrap);
        check("reset_cnt", cnt, 8'h00);
        check("reset_wrap", {7'd0, wrap}, 8'h00);

        // Up count through a full wrap.
        rst   = 1'b1;
        model = 0;
        for (int i = 0; i < 100; i++) begin
            check("up_tc", {7'd0, tc}, {7'd0, (model == 99)});
            tick();
            model = (model + 1) % 100;
            check("up_cnt", cnt, to_bcd(model));
            check("up_wrap", {7'd0, wrap}, {7'd0, (model == 0)});
        end
        $display("up wrap: cnt=%h wrap=%b", cnt, wrap);
        en = 1'b0;
        tick();
        $display("hold: cnt=%h wrap=%b tc=%b", cnt, wrap, tc);
        check("hold_cnt", cnt, 8'h00);
        check("wrap_one_cycle", {7'd0, wrap}, 8'h00);
        check("tc_no_en", {7'd0, tc}, 8'h00);

        // Load with per-digit clamp.
        load = 1'b1; load_val = 8'hA7;
        tick();
        $display("load A7: cnt=%h", cnt);
        check("load_clamp_hi", cnt, 8'h07);
        load_val = 8'h38;
        tick();
        $display("load 38: cnt=%h", cnt);
        check("load_legal", cnt, 8'h38);
        load_val = 8'h9F;
        tick();
        $display("load 9F: cnt=%h", cnt);
        check("load_clamp_lo", cnt, 8'h90);

        // Load beats en while tc is high.
        load_val = 8'h99;
        tick();
        load = 1'b0; en = 1'b1;
        #1;
        check("tc_at_99", {7'd0, tc}, 8'h01);
        load = 1'b1; load_val = 8'h50;
        #1;
        check("tc_ignores_load", {7'd0, tc}, 8'h01);
        tick();
        $display("load over tc: cnt=%h wrap=%b", cnt, wrap);
        check("conflict_cnt", cnt, 8'h50);
        check("conflict_wrap", {7'd0, wrap}, 8'h00);

        // Reset beats load.
        rst = 1'b0;
        tick();
        $display("reset over load: cnt=%h wrap=%b", cnt, wrap);
        check("rst_over_load", cnt, 8'h00);

        // Reset at 99 with en high suppresses the wrap pulse.
        rst = 1'b1; load = 1'b1; load_val = 8'h99;
        tick();
        load = 1'b0; en = 1'b1; rst = 1'b0;
        tick();
        $display("reset at 99: cnt=%h wrap=%b", cnt, wrap);
        check("rst_wrap_cnt", cnt, 8'h00);
        check("rst_wrap_suppr", {7'd0, wrap}, 8'h00);
        rst = 1'b1;

`ifdef COUNTER_DOWN_EN
        // Down: 01 -> 00 -> 99 (wrap) -> 98.
        en = 1'b0; load = 1'b1; load_val = 8'h01;
        tick();
        load = 1'b0; up = 1'b0; en = 1'b1;
        #1;
        check("dn_tc_01", {7'd0, tc}, 8'h00);
        tick();
        $display("down: cnt=%h wrap=%b tc=%b", cnt, wrap, tc);
        check("dn_cnt_00", cnt, 8'h00);
        check("dn_tc_00", {7'd0, tc}, 8'h01);
        tick();
        $display("down: cnt=%h wrap=%b", cnt, wrap);
        check("dn_cnt_99", cnt, 8'h99);
        check("dn_wrap", {7'd0, wrap}, 8'h01);
        tick();
        $display("down: cnt=%h wrap=%b", cnt, wrap);
        check("dn_cnt_98", cnt, 8'h98);
        check("dn_wrap_off", {7'd0, wrap}, 8'h00);

        // Direction change takes effect on the very next edge.
        up = 1'b1;
        tick();
        $display("dir change: cnt=%h", cnt);
        check("dir_chg_99", cnt, 8'h99);
        check("up_tc_99", {7'd0, tc}, 8'h01);
        tick();
        $display("dir change: cnt=%h wrap=%b", cnt, wrap);
        check("dir_chg_00", cnt, 8'h00);
        check("dir_chg_wrap", {7'd0, wrap}, 8'h01);
`else
        // Up-only build: up=0 still counts up.
        en = 1'b0; load = 1'b1; load_val = 8'h05;
        tick();
        load = 1'b0; up = 1'b0; en = 1'b1;
        tick();
        $display("up-only: cnt=%h", cnt);
        check("uponly_06", cnt, 8'h06);
        tick();
        $display("up-only: cnt=%h", cnt);
        check("uponly_07", cnt, 8'h07);
        load = 1'b1; load_val = 8'h99;
        tick();
        load = 1'b0;
        #1;
        check("uponly_tc_99", {7'd0, tc}, 8'h01);
        tick();
        $display("up-only: cnt=%h wrap=%b", cnt, wrap);
        check("uponly_wrap_cnt", cnt, 8'h00);
        check("uponly_wrap", {7'd0, wrap}, 8'h01);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bcd_counter_n
